tx_port_channel_reader_128: RTL

- Read-side consumer of the 129-bit TX channel-gate FIFO stream, sitting in the RD_CLK domain of the TX port.
- Decodes the framed FIFO sequence {HDR, HDR, DATA*, END, END} into two outputs:
  - a transaction descriptor (len/off/last) with a valid/ready handshake;
  - a 128-bit data stream with a valid/ready handshake.
- On close, reports a completion pulse, the received dword count, and length/protocol errors.

---
 rtl/tx_port_channel_reader_128.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tx_port_channel_reader_128.sv
// tx_port_channel_reader_128
//   Read-side consumer of the 129-bit TX channel-gate FIFO stream. Decodes the
//   framed sequence {HDR, HDR, DATA*, END, END} into a transaction descriptor
//   and a 128-bit payload stream, then reports a one-cycle completion pulse
//   with the received dword count and error flags.
//
//   Handshakes: a transfer happens on a CLK edge where VALID and READY are both
//   1. A source raises VALID without waiting for READY and holds VALID and its
//   payload stable until the transfer.
//
//   Optional feature macro: TX_READER_STATS_EN adds the STAT_TXNS / STAT_ERRS
//   counters and their output ports.
//
// Ports
//   CLK, RST_N          clock, synchronous active-low reset
//   RD_DATA, RD_EMPTY   first-word-fall-through FIFO head and empty flag
//   RD_EN               pops the FIFO head (never while RD_EMPTY=1)
//   TXN_VALID/READY     descriptor handshake; TXN_LEN/OFF/LAST payload
//   DATA, DATA_VALID/READY  payload stream handshake
//   DONE                one-cycle pulse at transaction close
//   DONE_WORDS, ERR_LEN valid while DONE=1
//   ERR_PROTO           sticky framing-violation flag
//   STAT_TXNS/STAT_ERRS transaction and error counters (feature macro only)
//   DBG_STATE           current FSM state
module tx_port_channel_reader_128 #(
   parameter int C_DATA_WIDTH      = 128,
   parameter int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic [C_FIFO_DATA_WIDTH-1:0] RD_DATA,
   input  logic                         RD_EMPTY,
   output logic                         RD_EN,
   output logic                         TXN_VALID,
   input  logic                         TXN_READY,
   output logic [31:0]                  TXN_LEN,
   output logic [30:0]                  TXN_OFF,
   output logic                         TXN_LAST,
   output logic [C_DATA_WIDTH-1:0]      DATA,
   output logic                         DATA_VALID,
   input  logic                         DATA_READY,
   output logic                         DONE,
   output logic [31:0]                  DONE_WORDS,
   output logic                         ERR_LEN,
   output logic                         ERR_PROTO,
`ifdef TX_READER_STATS_EN
   output logic [15:0]                  STAT_TXNS,
   output logic [15:0]                  STAT_ERRS,
`endif
   output logic [2:0]                   DBG_STATE
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR2 = 3'd1,
      S_DESC = 3'd2,
      S_DATA = 3'd3,
      S_END2 = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t      state, state_next;
   logic        flag;
   logic        head;
   logic        pop;
   logic        proto_set;
   logic        hdr_latch;
   logic        data_valid_c;
   logic        txn_valid;
   logic [31:0] txn_len;
   logic [30:0] txn_off;
   logic        txn_last;
   logic [32:0] cnt;
   logic        err_proto;
   logic        err_len_c;

   assign flag = RD_DATA[C_DATA_WIDTH];
   assign head = !RD_EMPTY;

   // Header and END entries look alike; only the state tells them apart.
   always_comb begin
      state_next   = state;
      pop          = 1'b0;
      proto_set    = 1'b0;
      hdr_latch    = 1'b0;
      data_valid_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (head) begin
               pop = 1'b1;
               if (flag) begin
                  hdr_latch  = 1'b1;
                  state_next = S_HDR2;
               end else begin
                  // Stray payload outside a frame is dropped.
                  proto_set = 1'b1;
               end
            end
         end
         S_HDR2: begin
            if (head) begin
               state_next = S_DESC;
               if (flag) pop = 1'b1;
               else      proto_set = 1'b1;  // leave the payload word for DATA
            end
         end
         S_DESC: begin
            if (txn_valid && TXN_READY) state_next = S_DATA;
         end
         S_DATA: begin
            if (head) begin
               if (flag) begin
                  // END is consumed regardless of DATA_READY.
                  pop        = 1'b1;
                  state_next = S_END2;
               end else begin
                  data_valid_c = 1'b1;
                  pop          = DATA_READY;
               end
            end
         end
         S_END2: begin
            if (head) begin
               state_next = S_DONE;
               if (flag) pop = 1'b1;
               else      proto_set = 1'b1;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Length check at 33 bits so len+4 cannot wrap.
   assign err_len_c = (cnt < {1'b0, txn_len}) || (cnt >= ({1'b0, txn_len} + 33'd4));

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         txn_valid <= 1'b0;
         txn_len   <= '0;
         txn_off   <= '0;
         txn_last  <= 1'b0;
         cnt       <= '0;
         err_proto <= 1'b0;
      end else begin
         state     <= state_next;
         txn_valid <= (state_next == S_DESC);
         if (hdr_latch) begin
            txn_len  <= RD_DATA[63:32];
            txn_off  <= RD_DATA[31:1];
            txn_last <= RD_DATA[0];
         end
         if (proto_set) err_proto <= 1'b1;
         if (state == S_DONE)
            cnt <= '0;
         else if (state == S_DATA && pop && !flag)
            cnt <= cnt + 33'd4;
      end
   end

`ifdef TX_READER_STATS_EN
   logic [15:0] stat_txns;
   logic [15:0] stat_errs;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stat_txns <= '0;
         stat_errs <= '0;
      end else if (state == S_DONE) begin
         stat_txns <= stat_txns + 16'd1;
         if (err_len_c || err_proto) stat_errs <= stat_errs + 16'd1;
      end
   end

   assign STAT_TXNS = stat_txns;
   assign STAT_ERRS = stat_errs;
`endif

   // RD_EN is forced low while reset is held, before the state register clears.
   assign RD_EN      = pop && RST_N;
   assign TXN_VALID  = txn_valid;
   assign TXN_LEN    = txn_len;
   assign TXN_OFF    = txn_off;
   assign TXN_LAST   = txn_last;
   assign DATA       = RD_DATA[C_DATA_WIDTH-1:0];
   assign DATA_VALID = data_valid_c;
   assign DONE       = (state == S_DONE);
   assign DONE_WORDS = cnt[32] ? 32'hFFFF_FFFF : cnt[31:0];
   assign ERR_LEN    = (state == S_DONE) && err_len_c;
   assign ERR_PROTO  = err_proto;
   assign DBG_STATE  = state;

endmodule
